// File: rtl/gamma_pkg.sv
// Shared encodings for the gamma-correction pipeline: pixel modes and
// table-management FSM states.
package gamma_pkg;

  typedef enum logic [1:0] {
    GM_BYPASS = 2'b00,
    GM_HALVE  = 2'b01,
    GM_LUT    = 2'b10
  } gamma_mode_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } gamma_state_e;

endpackage

// File: rtl/gamma_lut_bank.sv
// One copy of a gamma curve: 2^DATA_W x DATA_W RAM, single write port and a
// registered read port (read-first on same-address collisions).
module gamma_lut_bank #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DATA_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gamma_lut_pipe.sv
// Pipelined per-channel gamma correction with a double-buffered curve table
// that only swaps banks at start-of-frame.
module gamma_lut_pipe
  import gamma_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic [1:0]                   iMODE,
  input  logic                         iSOF,
  input  logic                         iDVAL,
  input  logic [CHANNELS*DATA_W-1:0]   iDATA,
  input  logic                         iWR_EN,
  input  logic [DATA_W-1:0]            iWR_ADDR,
  input  logic [DATA_W-1:0]            iWR_DATA,
  input  logic                         iCOMMIT,
  output logic                         oDVAL,
  output logic [CHANNELS*DATA_W-1:0]   oDATA,
  output logic                         oREADY
);

  localparam int PIX_W = CHANNELS * DATA_W;

  function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x);
    return x >> 1;
  endfunction

  gamma_state_e      state_q, state_d;
  logic [DATA_W:0]   cnt_q, cnt_d;
  logic              bank_q, bank_d;
  logic [1:0]        mode_q, mode_d;

  logic              in_init, init_done, latch, usr_we;
  logic [1:0]        mode_eff;
  logic [1:0]        bank_we;
  logic [DATA_W-1:0] waddr, wdata;
  logic [PIX_W-1:0]  rd0, rd1;

  // cnt_q MSB set means every address has been written with identity
  assign in_init   = (state_q == ST_INIT) && !cnt_q[DATA_W];
  assign init_done = (state_q == ST_INIT) &&  cnt_q[DATA_W];
  assign latch     = iSOF || init_done;
  assign usr_we    = iWR_EN && ((state_q == ST_RUN) || (state_q == ST_PEND));
  assign mode_eff  = in_init ? GM_BYPASS : (latch ? iMODE : mode_q);
  assign oREADY    = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    mode_d  = mode_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q[DATA_W]) state_d = ST_RUN;
        else               cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (iCOMMIT) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (iSOF) begin
          state_d = ST_RUN;
          bank_d  = ~bank_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (latch) mode_d = iMODE;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      mode_q  <= GM_BYPASS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      mode_q  <= mode_d;
    end
  end

  // Init fills both banks; afterwards only the shadow (~bank_q) is writable,
  // so a write on the swap cycle lands in the bank about to go active.
  assign bank_we[0] = in_init || (usr_we &&  bank_q);
  assign bank_we[1] = in_init || (usr_we && !bank_q);
  assign waddr      = in_init ? cnt_q[DATA_W-1:0] : iWR_ADDR;
  assign wdata      = in_init ? cnt_q[DATA_W-1:0] : iWR_DATA;

  // Stage p1: both banks are read every cycle; the bank choice travels along
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gamma_lut_bank #(.DATA_W(DATA_W)) u_bank0 (
      .clk_i   (iCLK),
      .we_i    (bank_we[0]),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (iDATA[c*DATA_W +: DATA_W]),
      .rdata_o (rd0[c*DATA_W +: DATA_W])
    );
    gamma_lut_bank #(.DATA_W(DATA_W)) u_bank1 (
      .clk_i   (iCLK),
      .we_i    (bank_we[1]),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (iDATA[c*DATA_W +: DATA_W]),
      .rdata_o (rd1[c*DATA_W +: DATA_W])
    );
  end

  logic             vld_p1_q, bank_p1_q;
  logic [1:0]       mode_p1_q;
  logic [PIX_W-1:0] data_p1_q;
  logic             vld_p2_q;
  logic [PIX_W-1:0] data_p2_q;
  logic [PIX_W-1:0] pix_sel;

  always_ff @(posedge iCLK) begin
    data_p1_q <= iDATA;
  end

  always_comb begin
    pix_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_p1_q)
        GM_HALVE: pix_sel[c*DATA_W +: DATA_W] = halve(data_p1_q[c*DATA_W +: DATA_W]);
        GM_LUT:   pix_sel[c*DATA_W +: DATA_W] = bank_p1_q ? rd1[c*DATA_W +: DATA_W]
                                                          : rd0[c*DATA_W +: DATA_W];
        default:  pix_sel[c*DATA_W +: DATA_W] = data_p1_q[c*DATA_W +: DATA_W];
      endcase
    end
  end

  // Stage p2: mode select register; output holds while no valid pixel arrives
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vld_p1_q  <= 1'b0;
      bank_p1_q <= 1'b0;
      mode_p1_q <= GM_BYPASS;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q  <= iDVAL;
      bank_p1_q <= bank_d;
      mode_p1_q <= mode_eff;
      vld_p2_q  <= vld_p1_q;
      if (vld_p1_q) data_p2_q <= pix_sel;
    end
  end

  assign oDVAL = vld_p2_q;
  assign oDATA = data_p2_q;

endmodule

// File: tb/tb_gamma_lut_pipe.sv
// Directed-plus-random bench for gamma_lut_pipe against a curve/frame model.
module tb_gamma_lut_pipe;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int PW = DW * CH;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [1:0]    iMODE = 2'b00;
  logic          iSOF = 1'b0;
  logic          iDVAL = 1'b0;
  logic [PW-1:0] iDATA = '0;
  logic          iWR_EN = 1'b0;
  logic [DW-1:0] iWR_ADDR = '0;
  logic [DW-1:0] iWR_DATA = '0;
  logic          iCOMMIT = 1'b0;
  logic          oDVAL;
  logic [PW-1:0] oDATA;
  logic          oREADY;

  gamma_lut_pipe #(.DATA_W(DW), .CHANNELS(CH)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iMODE(iMODE), .iSOF(iSOF), .iDVAL(iDVAL),
    .iDATA(iDATA), .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .iCOMMIT(iCOMMIT), .oDVAL(oDVAL), .oDATA(oDATA), .oREADY(oREADY)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad = 0;

  // Reference model: the curve in use, the curve being edited, frame mode
  logic [DW-1:0] act [256];
  logic [DW-1:0] shd [256];
  bit            pend;
  logic [1:0]    mode_f;
  int            init_k;
  bit            prev_vld;
  logic [PW-1:0] prev_data;
  bit            exp_vld;
  logic [PW-1:0] exp_data;
  bit            exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      act[i] = 8'(i);
      shd[i] = 8'(i);
    end
    pend = 0; mode_f = 2'b00; init_k = 0;
    prev_vld = 0; prev_data = '0; exp_vld = 0; exp_data = '0; exp_rdy = 0;
  endtask

  function automatic logic [PW-1:0] apply(input logic [PW-1:0] d, input logic [1:0] m);
    logic [PW-1:0] r;
    logic [DW-1:0] x;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      x = d[c*DW +: DW];
      if (m == 2'b01)      r[c*DW +: DW] = x / 2;
      else if (m == 2'b10) r[c*DW +: DW] = act[x];
      else                 r[c*DW +: DW] = x;
    end
    return r;
  endfunction

  task automatic model_cycle(input bit sof, input bit dval, input logic [PW-1:0] d,
                             input logic [1:0] m, input bit wen, input logic [DW-1:0] wa,
                             input logic [DW-1:0] wd, input bit commit);
    logic [PW-1:0] y;
    logic [DW-1:0] t;
    bit pend0;
    if (init_k < 256) begin
      init_k++;
      y = d;
    end else if (init_k == 256) begin
      init_k++;
      mode_f = m;
      y = apply(d, mode_f);
    end else begin
      pend0 = pend;
      if (wen) shd[wa] = wd;
      if (sof) mode_f = m;
      if (sof && pend0) begin
        for (int i = 0; i < 256; i++) begin
          t = act[i]; act[i] = shd[i]; shd[i] = t;
        end
        pend = 0;
      end
      if (commit && !pend0) pend = 1;
      y = apply(d, mode_f);
    end
    exp_vld = prev_vld;
    if (prev_vld) exp_data = prev_data;
    prev_vld  = dval;
    prev_data = y;
    exp_rdy   = (init_k > 256) && !pend;
  endtask

  task automatic step(input bit sof, input bit dval, input logic [PW-1:0] d,
                      input logic [1:0] m, input bit wen, input logic [DW-1:0] wa,
                      input logic [DW-1:0] wd, input bit commit);
    iSOF = sof; iDVAL = dval; iDATA = d; iMODE = m;
    iWR_EN = wen; iWR_ADDR = wa; iWR_DATA = wd; iCOMMIT = commit;
    model_cycle(sof, dval, d, m, wen, wa, wd, commit);
    @(posedge iCLK);
    #1;
    chk("dval", 32'(oDVAL), 32'(exp_vld));
    chk("data", 32'(oDATA), 32'(exp_data));
    chk("ready", 32'(oREADY), 32'(exp_rdy));
  endtask

  task automatic px(input bit sof, input logic [PW-1:0] d, input logic [1:0] m);
    step(sof, 1'b1, d, m, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle(input logic [1:0] m);
    step(1'b0, 1'b0, PW'($urandom()), m, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rand_frames(input int n, input int len);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < len; i++) begin
        step(i == 0, 1'($urandom()), PW'($urandom()), 2'($urandom()),
             1'b0, '0, '0, 1'b0);
      end
    end
  endtask

  task automatic run_init();
    for (int k = 1; k <= 257; k++) begin
      step(($urandom() % 8) == 0, 1'($urandom()), PW'($urandom()), 2'($urandom()),
           (k % 16) == 5, DW'($urandom()), DW'($urandom()), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(posedge iCLK);
    #1;
    chk("rst_dval", 32'(oDVAL), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_ready", 32'(oREADY), 32'd0);
    @(posedge iCLK);
    #4;
    iRST_N = 1'b1;

    // table init: ready low for 256 cycles, writes ignored, pixels bypassed
    run_init();

    px(1'b1, 24'h1080FF, 2'b10);
    idle(2'b10);
    chk("init_identity", 32'(oDATA), 32'h1080FF);
    rand_frames(2, 20);

    px(1'b1, 24'hFF8001, 2'b01);
    idle(2'b01);
    chk("halve", 32'(oDATA), 32'h7F4000);
    px(1'b1, 24'hFF8001, 2'b00);
    idle(2'b00);
    chk("bypass", 32'(oDATA), 32'hFF8001);

    // load inverse curve into the shadow while LUT pixels run
    px(1'b1, PW'($urandom()), 2'b10);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'($urandom()), PW'($urandom()), 2'b10, 1'b1, 8'(k), 8'(255 - k), 1'b0);
    end
    step(1'b0, 1'b0, '0, 2'b10, 1'b0, '0, '0, 1'b1);
    chk("commit_ready_low", 32'(oREADY), 32'd0);
    px(1'b0, 24'h101010, 2'b10);
    idle(2'b10);
    chk("pre_sof_identity", 32'(oDATA), 32'h101010);
    px(1'b1, 24'h101010, 2'b10);
    idle(2'b10);
    chk("lut_inverse", 32'(oDATA), 32'hEFEFEF);
    chk("ready_after_swap", 32'(oREADY), 32'd1);

    px(1'b0, 24'h203040, 2'b00);
    idle(2'b00);
    chk("midframe_mode", 32'(oDATA), 32'hDFCFBF);
    px(1'b1, 24'h203040, 2'b00);
    idle(2'b00);
    chk("new_frame_bypass", 32'(oDATA), 32'h203040);

    // random curve into shadow, then commit coincident with SOF
    px(1'b1, PW'($urandom()), 2'b10);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'($urandom()), PW'($urandom()), 2'b10, 1'b1, 8'(k), DW'($urandom()), 1'b0);
    end
    step(1'b1, 1'b1, PW'($urandom()), 2'b10, 1'b0, '0, '0, 1'b1);
    px(1'b0, 24'h101010, 2'b10);
    idle(2'b10);
    chk("no_swap_same_sof", 32'(oDATA), 32'hEFEFEF);
    step(1'b0, 1'b0, '0, 2'b10, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 2'b10, 1'b1, 8'h5A, 8'hC3, 1'b0);
    px(1'b0, 24'h5A5A5A, 2'b10);
    idle(2'b10);
    chk("swap_cycle_write", 32'(oDATA), 32'hC3C3C3);
    step(1'b0, 1'b0, '0, 2'b10, 1'b0, '0, '0, 1'b1);
    px(1'b1, 24'h5A5A5A, 2'b10);
    idle(2'b10);
    chk("old_active_clean", 32'(oDATA), 32'hA5A5A5);
    rand_frames(4, 16);

    // async reset mid-frame with the inverse curve active
    px(1'b0, PW'($urandom()), 2'b10);
    px(1'b0, PW'($urandom()), 2'b10);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_dval", 32'(oDVAL), 32'd0);
    chk("mid_rst_data", 32'(oDATA), 32'd0);
    chk("mid_rst_ready", 32'(oREADY), 32'd0);
    model_reset();
    @(posedge iCLK);
    @(posedge iCLK);
    #5;
    iRST_N = 1'b1;
    run_init();
    px(1'b1, 24'h10F05A, 2'b10);
    idle(2'b10);
    chk("reinit_identity", 32'(oDATA), 32'h10F05A);
    rand_frames(3, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
